twiddle_rom_seq: RTL and testbench

//  Parametrised twiddle-factor sequencer for the radix-4 pipelined FFT. Streams LANES packed

---
 rtl/twiddle_rom_seq_if.sv | 24 ++
 rtl/twiddle_rom_seq.sv | 159 +++++++++++++++
 tb/tb_twiddle_rom_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_rom_seq_if.sv
// Twiddle sequencer bus: sweep control toward the sequencer and packed twiddle
// lanes back to the butterfly datapath.
//   master : drives START/STAGE/INV/STALL, receives OR/OI/VLD/RDY/BUSY
//   slave  : the sequencer side
interface twiddle_rom_seq_if #(
   parameter int NB    = 9,
   parameter int LANES = 4,
   parameter int SW    = 2
);
   logic                START;
   logic [SW-1:0]       STAGE;
   logic                INV;
   logic                STALL;
   logic [NB*LANES-1:0] OR;
   logic [NB*LANES-1:0] OI;
   logic                VLD;
   logic                RDY;
   logic                BUSY;

   modport master (output START, STAGE, INV, STALL,
                   input  OR, OI, VLD, RDY, BUSY);
   modport slave  (input  START, STAGE, INV, STALL,
                   output OR, OI, VLD, RDY, BUSY);
endinterface

// File: rtl/twiddle_rom_seq.sv
// Twiddle-factor sequencer for the radix-4 pipelined FFT.
// Streams LANES packed twiddle pairs per group over G = NPT/LANES groups, each
// group presented for HOLD non-stalled cycles. Per-stage group aliasing clears
// the low min(2*STAGE, log2 G) group bits; INV conjugates (flips the sign of
// non-zero imaginary parts).
// Tables are supplied as packed parameters, entry n at [NB*(n+1)-1:NB*n].
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous reset, active-high, dominates everything
//   bus  slave side of twiddle_rom_seq_if
//        START/STAGE/INV : begin or restart a sweep (STAGE/INV sampled here)
//        STALL           : freeze sweep and outputs
//        OR/OI           : registered real/imag lanes, lane k at [NB*(k+1)-1:NB*k]
//        VLD/BUSY        : valid group / sweep in progress
//        RDY             : pulse on the final output cycle of a completed sweep
module twiddle_rom_seq #(
   parameter int                  NB     = 9,
   parameter int                  LANES  = 4,
   parameter int                  NPT    = 32,
   parameter int                  HOLD   = 4,
   parameter int                  SW     = 2,
   parameter logic [NPT*NB-1:0]   WR_TAB = '0,
   parameter logic [NPT*NB-1:0]   WI_TAB = '0
) (
   input  logic              CLK,
   input  logic              RST,
   twiddle_rom_seq_if.slave  bus
);
   localparam int G  = NPT / LANES;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                       state, state_nx;
   logic [GW-1:0]                grp, grp_nx, ld_grp, ga;
   logic [HW-1:0]                hold, hold_nx;
   logic [SW-1:0]                stg_q, stg_nx;
   logic                         inv_q, inv_nx, ld_inv;
   logic                         vld_q, vld_nx, busy_q, busy_nx;
   logic                         load, rdy, last;
   logic [LANES-1:0][NB-1:0]     or_q, oi_q, or_d, oi_d;
   int                           sh;

   assign last = (grp == GW'(G - 1)) && (hold == HW'(HOLD - 1));

   always_comb begin
      state_nx = state;
      grp_nx   = grp;
      hold_nx  = hold;
      stg_nx   = stg_q;
      inv_nx   = inv_q;
      vld_nx   = vld_q;
      busy_nx  = busy_q;
      load     = 1'b0;
      ld_grp   = grp;
      ld_inv   = inv_q;
      rdy      = 1'b0;
      case (state)
         IDLE: begin
            // First group appears one edge later (fill cycle with VLD=0).
            if (bus.START) begin
               state_nx = RUN;
               grp_nx   = '0;
               hold_nx  = '0;
               stg_nx   = bus.STAGE;
               inv_nx   = bus.INV;
            end
         end
         RUN: begin
            if (bus.START) begin
               // Restart: group 0 always maps to address 0, so load it now
               // with the freshly sampled INV.
               grp_nx  = '0;
               hold_nx = '0;
               stg_nx  = bus.STAGE;
               inv_nx  = bus.INV;
               load    = 1'b1;
               ld_grp  = '0;
               ld_inv  = bus.INV;
               vld_nx  = 1'b1;
               busy_nx = 1'b1;
            end else if (!bus.STALL) begin
               if (!vld_q) begin
                  load    = 1'b1;
                  vld_nx  = 1'b1;
                  busy_nx = 1'b1;
               end else if (last) begin
                  rdy      = 1'b1;
                  state_nx = IDLE;
                  vld_nx   = 1'b0;
                  busy_nx  = 1'b0;
                  grp_nx   = '0;
                  hold_nx  = '0;
               end else if (hold == HW'(HOLD - 1)) begin
                  hold_nx = '0;
                  grp_nx  = grp + 1'b1;
                  load    = 1'b1;
                  ld_grp  = grp + 1'b1;
               end else begin
                  hold_nx = hold + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stage aliasing: clear the low min(2*STAGE, log2 G) bits of the group.
   always_comb begin
      sh = 2 * int'(stg_q);
      if (sh > GW) sh = GW;
      ga = '0;
      for (int b = 0; b < GW; b++)
         if (b >= sh) ga[b] = ld_grp[b];
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [NB-1:0] raw_r, raw_i;
      assign raw_r   = WR_TAB[NB*(LANES*int'(ga) + k) +: NB];
      assign raw_i   = WI_TAB[NB*(LANES*int'(ga) + k) +: NB];
      assign or_d[k] = raw_r;
      // Zero magnitude keeps its encoding; only non-zero values change sign.
      assign oi_d[k] = (ld_inv && raw_i[NB-2:0] != '0) ?
                       {~raw_i[NB-1], raw_i[NB-2:0]} : raw_i;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         grp    <= '0;
         hold   <= '0;
         stg_q  <= '0;
         inv_q  <= 1'b0;
         vld_q  <= 1'b0;
         busy_q <= 1'b0;
         or_q   <= '0;
         oi_q   <= '0;
      end else begin
         state  <= state_nx;
         grp    <= grp_nx;
         hold   <= hold_nx;
         stg_q  <= stg_nx;
         inv_q  <= inv_nx;
         vld_q  <= vld_nx;
         busy_q <= busy_nx;
         if (load) begin
            or_q <= or_d;
            oi_q <= oi_d;
         end
      end
   end

   assign bus.OR   = or_q;
   assign bus.OI   = oi_q;
   assign bus.VLD  = vld_q;
   assign bus.BUSY = busy_q;
   assign bus.RDY  = rdy & ~RST;
endmodule

// File: tb/tb_twiddle_rom_seq.sv
module tb_twiddle_rom_seq;
   localparam int NB = 9, LANES = 4, NPT = 32, HOLD = 4, SW = 2;
   localparam int G = NPT / LANES;
   localparam int LG = $clog2(G);
   localparam int SWEEP = G * HOLD;

   // Synthetic table with the known reference entries placed at their slots.
   function automatic logic [NPT*NB-1:0] mk_tab(input bit im);
      logic [NPT*NB-1:0] t;
      for (int n = 0; n < NPT; n++)
         t[n*NB +: NB] = NB'((n * 37 + (im ? 101 : 11)) % 512);
      if (!im) begin
         t[0*NB  +: NB] = 9'b010000000;
         t[4*NB  +: NB] = 9'b001111011;
         t[16*NB +: NB] = 9'b101110111;
      end else begin
         for (int n = 0; n < 4; n++) t[n*NB +: NB] = '0;
         t[4*NB  +: NB] = 9'b101110010;
         t[5*NB  +: NB] = 9'b100000000;
         t[16*NB +: NB] = 9'b101110111;
         t[17*NB +: NB] = 9'b110000000;
      end
      return t;
   endfunction

   localparam logic [NPT*NB-1:0] WR = mk_tab(1'b0);
   localparam logic [NPT*NB-1:0] WI = mk_tab(1'b1);

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   twiddle_rom_seq_if #(.NB(NB), .LANES(LANES), .SW(SW)) bus ();

   twiddle_rom_seq #(.NB(NB), .LANES(LANES), .NPT(NPT), .HOLD(HOLD), .SW(SW),
                     .WR_TAB(WR), .WI_TAB(WI))
      dut (.CLK(CLK), .RST(RST), .bus(bus));

   int checks = 0, errors = 0;

   // reference model state
   logic [NB-1:0]       wr_a [NPT];
   logic [NB-1:0]       wi_a [NPT];
   bit                  m_active, m_inv, m_vld, m_busy;
   int                  m_pos, m_stage;
   logic [NB*LANES-1:0] m_or, m_oi;

   // sweep observation
   int                  nv, nr, rdy_at, nv_restart;
   bit                  last_vld;
   logic [NB*LANES-1:0] cap_or [64];
   logic [NB*LANES-1:0] cap_oi [64];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NB-1:0] conj(input logic [NB-1:0] x, input bit inv);
      int mag = int'(x) % (1 << (NB - 1));
      if (inv && mag != 0) return x ^ NB'(1 << (NB - 1));
      return x;
   endfunction

   task automatic present(input int g);
      int sh, ga;
      sh = 2 * m_stage;
      if (sh > LG) sh = LG;
      ga = (g / (1 << sh)) * (1 << sh);
      for (int k = 0; k < LANES; k++) begin
         m_or[NB*k +: NB] = wr_a[ga*LANES + k];
         m_oi[NB*k +: NB] = conj(wi_a[ga*LANES + k], m_inv);
      end
   endtask

   task automatic drive(input bit rst, input bit st, input int stage, input bit inv, input bit stl);
      RST       = rst;
      bus.START = st;
      bus.STAGE = SW'(stage);
      bus.INV   = inv;
      bus.STALL = stl;
   endtask

   // One cycle: check outputs against the model, then advance the model at the edge.
   task automatic step();
      bit exp_rdy;
      #1;
      exp_rdy = !RST && m_active && m_pos == SWEEP && !bus.STALL && !bus.START;
      chk("rdy",  bus.RDY,  exp_rdy);
      chk("vld",  bus.VLD,  m_vld);
      chk("busy", bus.BUSY, m_busy);
      chk("or",   bus.OR,   m_or);
      chk("oi",   bus.OI,   m_oi);
      last_vld = bus.VLD;
      if (bus.VLD) nv++;
      if (bus.RDY) begin nr++; rdy_at = nv; end
      if (nv < 64) begin cap_or[nv] = bus.OR; cap_oi[nv] = bus.OI; end
      @(posedge CLK);
      if (RST) begin
         m_active = 0; m_pos = 0; m_vld = 0; m_busy = 0; m_or = '0; m_oi = '0;
         m_stage = 0; m_inv = 0;
      end else if (bus.START) begin
         m_stage = int'(bus.STAGE);
         m_inv   = bus.INV;
         if (m_active) begin
            m_pos = 1; present(0); m_vld = 1; m_busy = 1;
         end else begin
            m_active = 1; m_pos = 0;
         end
      end else if (m_active && !bus.STALL) begin
         if (m_pos == SWEEP) begin
            m_active = 0; m_pos = 0; m_vld = 0; m_busy = 0;
         end else begin
            m_pos++; present((m_pos - 1) / HOLD); m_vld = 1; m_busy = 1;
         end
      end
      @(negedge CLK);
   endtask

   task automatic run_sweep(input int stage, input bit inv, input int stall_at,
                            input int stall_len, input int restart_at);
      bit done = 0, rs = 0, st, stl;
      int scnt = 0;
      nv = 0; nr = 0; rdy_at = 0; nv_restart = 0;
      for (int i = 0; i < 64; i++) begin cap_or[i] = '0; cap_oi[i] = '0; end
      drive(0, 1, stage, inv, 0);
      step();
      for (int c = 0; c < 200 && !done; c++) begin
         st = 0; stl = 0;
         if (restart_at > 0 && !rs && nv == restart_at) begin st = 1; rs = 1; end
         if (stall_at > 0 && nv >= stall_at && scnt < stall_len) begin stl = 1; scnt++; end
         drive(0, st, st ? stage : int'($urandom % 4), st ? inv : 1'($urandom), stl);
         step();
         if (st) nv_restart = nv;
         if (nv > 0 && !last_vld) done = 1;
      end
      chk("sweep_done", done, 1);
   endtask

   initial begin
      for (int n = 0; n < NPT; n++) begin
         wr_a[n] = WR[n*NB +: NB];
         wi_a[n] = WI[n*NB +: NB];
      end
      m_active = 0; m_pos = 0; m_vld = 0; m_busy = 0; m_or = '0; m_oi = '0;
      m_stage = 0; m_inv = 0;
      drive(1, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      step();
      chk("rst_or", bus.OR, '0);

      // plain sweep, stage 0
      run_sweep(0, 0, 0, 0, 0);
      chk("t2_len", nv, SWEEP);
      chk("t2_rdy_n", nr, 1);
      chk("t2_rdy_at", rdy_at, SWEEP);
      for (int c = 5; c <= 8; c++) begin
         chk("t2_or", cap_or[c][8:0], 9'b001111011);
         chk("t2_oi", cap_oi[c][8:0], 9'b101110010);
      end

      // stage 1 aliasing
      run_sweep(1, 0, 0, 0, 0);
      chk("t3_or1",  cap_or[1][8:0],   9'b010000000);
      chk("t3_or16", cap_or[16][8:0],  9'b010000000);
      chk("t3_or17", cap_or[17][8:0],  9'b101110111);
      chk("t3_oi32", cap_oi[32][17:9], 9'b110000000);

      // inverse conjugation
      run_sweep(0, 1, 0, 0, 0);
      chk("t4_oi_g4", cap_oi[17][8:0], 9'b001110111);
      chk("t4_oi_g0", cap_oi[1], '0);
      chk("t4_negzero", cap_oi[5][17:9], 9'b100000000);
      chk("t4_or_g1", cap_or[5][8:0], 9'b001111011);

      // stall inside group 2
      run_sweep(0, 0, 10, 5, 0);
      chk("t5_len", nv, SWEEP + 5);
      chk("t5_rdy_n", nr, 1);
      chk("t5_rdy_at", rdy_at, SWEEP + 5);

      // restart mid-sweep
      run_sweep(0, 0, 0, 0, 10);
      chk("t6_rdy_n", nr, 1);
      chk("t6_len", nv - nv_restart, SWEEP);
      chk("t6_rdy_at", rdy_at, nv);
      chk("t6_g0", cap_or[nv_restart + 1][8:0], 9'b010000000);

      // reset in the middle of a sweep
      drive(0, 1, 0, 0, 0);
      step();
      for (int c = 0; c < 12; c++) begin drive(0, 0, 0, 0, 0); step(); end
      drive(1, 0, 0, 0, 0);
      step();
      #1;
      chk("t1_vld", bus.VLD, 0);
      chk("t1_busy", bus.BUSY, 0);
      chk("t1_or", bus.OR, '0);
      chk("t1_oi", bus.OI, '0);
      nv = 0;
      for (int c = 0; c < 6; c++) begin drive(0, 0, 0, 0, 0); step(); end
      chk("t1_quiet", nv, 0);

      // randomized traffic against the model
      for (int c = 0; c < 2500; c++) begin
         drive(($urandom % 400) == 0, ($urandom % 70) == 0, int'($urandom % 4),
               1'($urandom), ($urandom % 5) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
